// File: rtl/byte_accumulator_pkg.sv
// Shared definitions for the byte accumulator: FSM states, default sizes
// and the width helper for the beat counter.
package byte_accumulator_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

    localparam int ACC_W_DEF = 12;
    localparam int N_MAX_DEF = 32;

    // Bits needed to hold a beat count from 0 up to and including n_max.
    function automatic int count_w(input int n_max);
        return $clog2(n_max + 1);
    endfunction

endpackage

// File: rtl/byte_accumulator_carry_select.sv
// 8-bit carry-select adder: the low nibble ripples, and the high nibble is
// precomputed for both carry-in values so the low carry only drives a mux.
module byte_accumulator_carry_select (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo_nib;
    logic [4:0] hi_c0;
    logic [4:0] hi_c1;

    // Low nibble with its real carry-in; high nibble both ways in parallel.
    always_comb begin
        lo_nib = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi_c0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi_c1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    end

    assign sum  = {(lo_nib[4] ? hi_c1[3:0] : hi_c0[3:0]), lo_nib[3:0]};
    assign cout = lo_nib[4] ? hi_c1[4] : hi_c0[4];

endmodule

// File: rtl/byte_accumulator.sv
// Frame accumulator: sums unsigned bytes until in_last or N_MAX beats, then
// presents sum, beat count and sticky overflow until downstream takes them.
module byte_accumulator
    import byte_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int N_MAX = N_MAX_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_sum,
    output logic [count_w(N_MAX)-1:0]   out_count,
    output logic                        out_ovf
);

    localparam int CNT_W = count_w(N_MAX);
    localparam int UP_W  = ACC_W - 8;
    localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(N_MAX);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       low_sum;
    logic             low_cout;
    logic [UP_W-1:0]  upper_sum;
    logic             upper_wrap;
    logic [CNT_W-1:0] count_inc;

    byte_accumulator_carry_select u_low_add (
        .a    (acc_q[7:0]),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (low_sum),
        .cout (low_cout)
    );

    // Upper field absorbs the low-byte carry; wrapping it is the overflow event.
    always_comb begin
        upper_sum  = acc_q[ACC_W-1:8] + UP_W'(low_cout);
        upper_wrap = low_cout & (&acc_q[ACC_W-1:8]);
        count_inc  = count_q + CNT_W'(1);
    end

    // Next-state logic: collect beats in ACC, wait for the consumer in HOLD.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    acc_d   = {upper_sum, low_sum};
                    count_d = count_inc;
                    ovf_d   = ovf_q | upper_wrap;
                    if (in_last || (count_inc == N_MAX_C)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State and frame registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_byte_accumulator.sv
// Self-checking bench for byte_accumulator: directed frames for the corner
// cases followed by random traffic, all against a frame-level integer model.
module tb_byte_accumulator;

    localparam int ACC_W = 12;
    localparam int N_MAX = 32;
    localparam int CNT_W = $clog2(N_MAX + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int compared = 0;
    int mismatched = 0;

    // Reference model: plain integer frame sum and beat count plus a flag for
    // "a result is being presented".
    int m_sum = 0;
    int m_cnt = 0;
    bit m_hold = 1'b0;

    byte_accumulator #(
        .ACC_W (ACC_W),
        .N_MAX (N_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare every visible output against the model after an edge.
    task automatic checkAll();
        checkOutput("in_ready", 32'(in_ready), 32'(!m_hold));
        checkOutput("out_valid", 32'(out_valid), 32'(m_hold));
        if (m_hold) begin
            checkOutput("out_sum", 32'(out_sum), 32'(m_sum % (1 << ACC_W)));
            checkOutput("out_count", 32'(out_count), 32'(m_cnt));
            checkOutput("out_ovf", 32'(out_ovf), 32'(m_sum > (1 << ACC_W) - 1));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check.
    task automatic applyStimulus(input bit v, input logic [7:0] d,
                                 input bit l, input bit ordy);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        if (!m_hold) begin
            if (v) begin
                m_sum += int'(d);
                m_cnt++;
                if (l || m_cnt == N_MAX) m_hold = 1'b1;
            end
        end else if (ordy) begin
            m_hold = 1'b0;
            m_sum  = 0;
            m_cnt  = 0;
        end
        @(posedge clk);
        #1;
        checkAll();
    endtask

    // One reset edge; inputs are left busy to show reset dominates.
    task automatic applyReset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_hold = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
        checkAll();
        checkOutput("rst_sum", 32'(out_sum), 32'd0);
        checkOutput("rst_count", 32'(out_count), 32'd0);
        checkOutput("rst_ovf", 32'(out_ovf), 32'd0);
    endtask

    initial begin
        bit         v, l, r;
        logic [7:0] d;

        applyReset();

        // 0xFF + 0x01 carries into the upper field.
        applyStimulus(1, 8'hFF, 0, 0);
        applyStimulus(1, 8'h01, 1, 0);
        checkOutput("r34_sum", 32'(out_sum), 32'h100);
        checkOutput("r34_count", 32'(out_count), 32'd2);
        applyStimulus(0, 8'h00, 0, 1);

        // Single-beat frame, consumed immediately, ready again next cycle.
        applyStimulus(1, 8'h05, 1, 0);
        checkOutput("r35_sum", 32'(out_sum), 32'h005);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("r35_ready", 32'(in_ready), 32'd1);

        // 17 x 0xFF overflows 12 bits.
        for (int i = 0; i < 17; i++) applyStimulus(1, 8'hFF, (i == 16), 0);
        checkOutput("r36_sum", 32'(out_sum), 32'h0EF);
        checkOutput("r36_count", 32'(out_count), 32'd17);
        checkOutput("r36_ovf", 32'(out_ovf), 32'd1);
        applyStimulus(0, 8'h00, 0, 1);

        // Auto-close at N_MAX; the extra beat waits for the HOLD exit.
        for (int i = 0; i < N_MAX; i++) applyStimulus(1, 8'h01, 0, 0);
        checkOutput("r37_count", 32'(out_count), 32'd32);
        applyStimulus(1, 8'h01, 0, 0);
        applyStimulus(1, 8'h01, 0, 1);
        applyStimulus(1, 8'h01, 1, 0);
        checkOutput("r37_next", 32'(out_count), 32'd1);
        applyStimulus(0, 8'h00, 0, 1);

        // Back-pressure with in_valid held high.
        applyStimulus(1, 8'h10, 0, 0);
        applyStimulus(1, 8'h20, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h55, 1, 0);
        checkOutput("r38_sum", 32'(out_sum), 32'h030);
        applyStimulus(1, 8'h55, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);

        // Reset mid-frame discards the partial sum.
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h80, 0, 0);
        applyReset();
        applyStimulus(1, 8'h07, 1, 0);
        checkOutput("r39_sum", 32'(out_sum), 32'h007);
        checkOutput("r39_count", 32'(out_count), 32'd1);
        applyStimulus(0, 8'h00, 0, 1);

        // Random traffic, biased toward large bytes now and then for overflow.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255))
                                            : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) applyReset();
            else applyStimulus(v, d, l, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
